// File: rtl/led_frame_loader_if.sv
// Byte-stream handshake into the LED frame loader: one colour byte per accept,
// with a start-of-frame marker that is only meaningful on an accepted byte.
interface led_frame_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_sof;

  modport master (output s_valid, output s_data, output s_sof, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_sof, output s_ready);
endinterface

// File: rtl/led_frame_loader.sv
// Assembles one frame of colour bytes in a shadow buffer and commits it atomically
// to the WS2812 driver bus, bit-reversed so the LSB-first driver emits bytes MSB-first.
module led_frame_loader #(
  parameter int LED_CNT        = 3,
  parameter int CHANNELS       = 3,
  parameter int TIMEOUT_CYCLES = 25000,
  localparam int NBYTES        = LED_CNT * CHANNELS,
  localparam int DATAWIDTH     = NBYTES * 8,
  localparam int IDXW          = $clog2(NBYTES + 1),
  localparam int TOW           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  led_frame_loader_if.slave    s,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 frame_done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
  localparam logic [TOW-1:0]  TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [TOW-1:0]  TO_MAX   = '1;
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_t                 state;
  logic [IDXW-1:0]        index;
  logic [TOW-1:0]         to_cnt;
  logic [DATAWIDTH-1:0]   shadow;

  logic                   accept;
  logic                   wr_en;
  logic [IDXW-1:0]        wr_idx;
  logic [7:0]             wr_byte;

  assign s.s_ready = !reset && (state != COMMIT);
  assign accept    = s.s_valid && s.s_ready;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = index;
    wr_byte = '0;
    for (int b = 0; b < 8; b++) begin
      wr_byte[b] = s.s_data[7 - b];
    end
    if (accept) begin
      wr_en = 1'b1;
      // Idle starts and mid-frame resyncs both restart the frame at byte 0.
      if (state == IDLE || s.s_sof) begin
        wr_idx = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: the shadow buffer is a plain register vector and is reset with everything else so
  // a stale partial frame never survives reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      to_cnt     <= '0;
      shadow     <= '0;
      data_o     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;

      for (int b = 0; b < NBYTES; b++) begin
        if (wr_en && wr_idx == IDXW'(b)) begin
          shadow[b*8 +: 8] <= wr_byte;
        end
      end

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (accept) begin
            if (NBYTES == 1) begin
              state <= COMMIT;
              index <= '0;
            end else begin
              state <= LOAD;
              index <= IDX_ONE;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            to_cnt <= '0;
            if (s.s_sof) begin
              err <= 1'b1;
              if (NBYTES == 1) begin
                state <= COMMIT;
                index <= '0;
              end else begin
                index <= IDX_ONE;
              end
            end else if (index == LAST_IDX) begin
              state <= COMMIT;
              index <= '0;
            end else begin
              index <= index + IDX_ONE;
            end
          end else if (to_cnt == TO_LAST) begin
            // Abandon the partial frame; the shadow stays stale and data_o is untouched.
            state  <= IDLE;
            index  <= '0;
            to_cnt <= '0;
            err    <= 1'b1;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        COMMIT: begin
          data_o     <= shadow;
          frame_done <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase
    end
  end

endmodule
